// File: rtl/edge_mem_host_if.sv
// Accelerator memory port, start/finish handshake and host image streams for edge_mem_host.
// The slave modport is the memory/sequencer side; the master modport is the host/accelerator side.
interface edge_mem_host_if;
  logic [15:0] addr;
  logic        en;
  logic        we;
  logic [31:0] dataW;
  logic [31:0] dataR;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  modport slave (
    input  addr, en, we, dataW, finish, in_valid, in_data, out_ready,
    output dataR, start, in_ready, out_valid, out_data, busy, done
  );

  modport master (
    output addr, en, we, dataW, finish, in_valid, in_data, out_ready,
    input  dataR, start, in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/edge_mem_host.sv
// Image memory and host sequencer (LOAD->KICK->RUN->DUMP->DONE); accelerator reads return one cycle later.
// Input accepted only in LOAD; result words leave at most one per two cycles and hold while out_ready is low.
module edge_mem_host #(
  parameter int WORDS_IN = 25344,
  parameter int OUT_BASE = 25344,
  parameter int DEPTH    = 50688
) (
  input logic            clk,
  input logic            reset,
  edge_mem_host_if.slave bus
);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = DEPTH;

  typedef enum logic [2:0] {S_LOAD, S_KICK, S_RUN, S_DUMP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] load_ptr_q, load_ptr_d;
  logic [PW-1:0] dump_ptr_q, dump_ptr_d;
  logic [31:0]   data_r_q, data_r_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic          in_fire, out_fire, acc_in_range, load_last, dump_last;
  logic [PW-1:0] acc_idx;
  logic [31:0]   acc_rd_word;

  assign in_fire      = (state_q == S_LOAD) && bus.in_valid;
  assign out_fire     = (state_q == S_DUMP) && out_valid_q && bus.out_ready;
  assign acc_in_range = {16'd0, bus.addr} < DEPTH_U;
  assign acc_idx      = PW'(bus.addr);
  assign load_last    = load_ptr_q == PW'(WORDS_IN - 1);
  assign dump_last    = dump_ptr_q == PW'(OUT_BASE + WORDS_IN - 1);
  // Out-of-range addresses never index the array; they read as zero.
  assign acc_rd_word  = acc_in_range ? mem[acc_idx] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (in_fire && load_last) state_d = S_KICK;
      S_KICK:  state_d = S_RUN;
      S_RUN:   if (bus.finish) state_d = S_DUMP;
      S_DUMP:  if (out_fire && dump_last) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.start    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_LOAD: bus.in_ready = 1'b1;
      S_KICK: begin
        bus.start = 1'b1;
        bus.busy  = 1'b1;
      end
      S_RUN:  bus.busy = 1'b1;
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    load_ptr_d  = load_ptr_q;
    dump_ptr_d  = dump_ptr_q;
    data_r_d    = data_r_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    mem_waddr   = load_ptr_q;
    mem_wdata   = bus.in_data;
    case (state_q)
      S_LOAD: if (in_fire) begin
        mem_we = 1'b1;
        if (!load_last) load_ptr_d = load_ptr_q + PW'(1);
      end
      S_RUN: if (bus.en) begin
        if (bus.we) begin
          mem_we    = acc_in_range;
          mem_waddr = acc_idx;
          mem_wdata = bus.dataW;
        end else begin
          data_r_d = acc_rd_word;
        end
      end
      // Alternate fetch and present: the cycle after each accept refetches.
      S_DUMP: if (!out_valid_q) begin
        out_data_d  = mem[dump_ptr_q];
        out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
        if (!dump_last) dump_ptr_d = dump_ptr_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ptr_q  <= '0;
      dump_ptr_q  <= PW'(OUT_BASE);
      data_r_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      load_ptr_q  <= load_ptr_d;
      dump_ptr_q  <= dump_ptr_d;
      data_r_q    <= data_r_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Contents survive reset; the host reloads after one.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.dataR     = data_r_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_edge_mem_host.sv
// Directed bench for edge_mem_host using a 64-word image at the real OUT_BASE/DEPTH so the full flow stays short.
module tb_edge_mem_host;
  localparam int W  = 64;
  localparam int OB = 25344;
  localparam int D  = 50688;

  logic clk;
  logic reset;
  edge_mem_host_if bus();

  edge_mem_host #(.WORDS_IN(W), .OUT_BASE(OB), .DEPTH(D)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int k, input int off);
    for (int i = 0; i < W; i++) begin
      if (i % 5 == 3) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(k * i + off);
      check("load_in_ready", bus.in_ready, 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("start_pulse", bus.start, 32'd1);
    check("kick_busy", bus.busy, 32'd1);
    tick();
    check("start_single", bus.start, 32'd0);
    check("run_busy", bus.busy, 32'd1);
  endtask

  task automatic acc_read(input int a, input logic [31:0] exp, input string tag);
    bus.en   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 16'(a);
    tick();
    bus.en = 1'b0;
    check(tag, bus.dataR, exp);
  endtask

  task automatic acc_write(input int a, input logic [31:0] d);
    bus.en    = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 16'(a);
    bus.dataW = d;
    tick();
    bus.en = 1'b0;
    bus.we = 1'b0;
  endtask

  // Stub accelerator: read word i, write its complement to OUT_BASE+i.
  task automatic stub_copy(input int k, input int off, input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = 32'(k * i + off);
      acc_read(i, v, "stub_rd");
      acc_write(OB + i, ~bus.dataR);
      sb.push_back(~v);
    end
  endtask

  task automatic finish_and_wait(input logic [31:0] exp7);
    bus.en     = 1'b1;
    bus.we     = 1'b0;
    bus.addr   = 16'd7;
    bus.finish = 1'b1;
    tick();
    bus.en     = 1'b0;
    bus.finish = 1'b0;
    check("finish_cycle_rd", bus.dataR, exp7);
    check("dump_nv_n1", bus.out_valid, 32'd0);
    check("dump_busy", bus.busy, 32'd0);
    check("dump_in_ready", bus.in_ready, 32'd0);
    tick();
    check("first_valid_n2", bus.out_valid, 32'd1);
  endtask

  task automatic dump(input int mode);
    int          got  = 0;
    int          cyc  = 0;
    int          pcnt = 0;
    logic        rdy;
    logic        prev_stall = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] exp;
    while (got < W && cyc < 10 * W + 20) begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 32'd1);
        check("stall_data", bus.out_data, held);
      end
      rdy = (mode == 1) ? 1'b1 : (pcnt % 3 == 2);
      pcnt++;
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        exp = sb.pop_front();
        check("dump_word", bus.out_data, exp);
        got++;
      end
      prev_stall = bus.out_valid && !rdy;
      held       = bus.out_data;
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("dump_count", 32'(got), 32'(W));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_after_dump", bus.done, 32'd1);
    check("done_not_busy", bus.busy, 32'd0);
    check("done_no_valid", bus.out_valid, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.addr      = '0;
    bus.en        = 1'b0;
    bus.we        = 1'b0;
    bus.dataW     = '0;
    bus.finish    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 32'd1);
    check("rst_start", bus.start, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_out_valid", bus.out_valid, 32'd0);
    check("rst_dataR", bus.dataR, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    reset = 1'b0;

    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    tick();
    check("load_finish_ignored_rdy", bus.in_ready, 32'd1);
    check("load_finish_ignored_busy", bus.busy, 32'd0);

    load_image(1, 0);
    acc_read(5, 32'h5, "rd_addr5");
    tick();
    check("dataR_hold_idle", bus.dataR, 32'h5);
    acc_write(OB, 32'hDEADBEEF);
    acc_read(OB, 32'hDEADBEEF, "rd_after_wr");
    acc_write(60000, 32'h12345678);
    acc_read(60000, 32'h0, "oor_read_zero");

    bus.in_valid = 1'b1;
    bus.in_data  = 32'hBAD0BAD0;
    tick();
    check("run_in_ready", bus.in_ready, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    acc_read(W - 1, 32'(W - 1), "run_host_no_write");
    acc_read(0, 32'h0, "run_word0_intact");

    stub_copy(1, 0, W);
    finish_and_wait(32'd7);
    dump(0);

    bus.en   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 16'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    check("done_dataR_hold", bus.dataR, 32'd7);
    check("done_in_ready", bus.in_ready, 32'd0);
    check("done_stays", bus.done, 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_image(3, 7);
    stub_copy(3, 7, 20);
    reset = 1'b1;
    #1;
    check("midrun_rst_in_ready", bus.in_ready, 32'd1);
    check("midrun_rst_start", bus.start, 32'd0);
    check("midrun_rst_busy", bus.busy, 32'd0);
    check("midrun_rst_out_valid", bus.out_valid, 32'd0);
    check("midrun_rst_dataR", bus.dataR, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();

    load_image(5, 11);
    stub_copy(5, 11, W);
    finish_and_wait(32'd46);
    dump(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
